// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: controller states,
// digit-select codes and a constant-evaluable clog2.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, PRE, CALC, DONE} state_t;

  typedef enum logic [3:0] {
    NOP, ADDM, ADD2M, ADD3M, ADD4M, SUBM, SUB2M, SUB3M, SUB4M
  } sel_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Booth recoder: one overlapping window of the multiplier in, one multiple-select code out.
module booth_digit_enc
  import booth_pkg::*;
#(
  parameter int RADIX_LOG2 = 3
) (
  input  logic [RADIX_LOG2:0] q,
  output sel_t                sel
);

  generate
    if (RADIX_LOG2 == 2) begin : g_r4
      always_comb begin
        sel = NOP;
        case (q)
          3'b001, 3'b010: sel = ADDM;
          3'b011:         sel = ADD2M;
          3'b100:         sel = SUB2M;
          3'b101, 3'b110: sel = SUBM;
          default:        sel = NOP;
        endcase
      end
    end else begin : g_r8
      always_comb begin
        sel = NOP;
        case (q)
          4'b0001, 4'b0010: sel = ADDM;
          4'b0011, 4'b0100: sel = ADD2M;
          4'b0101, 4'b0110: sel = ADD3M;
          4'b0111:          sel = ADD4M;
          4'b1000:          sel = SUB4M;
          4'b1001, 4'b1010: sel = SUB3M;
          4'b1011, 4'b1100: sel = SUB2M;
          4'b1101, 4'b1110: sel = SUBM;
          default:          sel = NOP;
        endcase
      end
    end
  endgenerate

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4/radix-8 Booth multiplier: one recoded digit per clock through
// a single adder, with Start/Done/Busy handshake and synchronous abort.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RADIX_LOG2 = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int EXT   = WIDTH + 1;
  localparam int STEPS = (EXT + RADIX_LOG2 - 1) / RADIX_LOG2;
  localparam int AW    = EXT + RADIX_LOG2;
  localparam int QW    = STEPS * RADIX_LOG2 + 1;
  localparam int CW    = (clog2(STEPS) < 1) ? 1 : clog2(STEPS);

  state_t                   state, state_n;
  logic signed [EXT-1:0]    m;
  logic signed [AW-1:0]     m3, acc;
  logic [QW-1:0]            q;
  logic [CW-1:0]            cnt;

  logic signed [EXT-1:0]    a_ext, b_ext;
  logic signed [QW-2:0]     b_wide;
  logic signed [AW-1:0]     m_wide, mag, addend, sum;
  logic signed [AW+QW-1:0]  shifted;
  logic                     neg, last;
  sel_t                     sel;

  assign a_ext  = {signed_mode & a[WIDTH-1], a};
  assign b_ext  = {signed_mode & b[WIDTH-1], b};
  assign b_wide = b_ext;
  assign m_wide = m;
  assign last   = (cnt == CW'(STEPS - 1));

  booth_digit_enc #(.RADIX_LOG2(RADIX_LOG2)) u_enc (
    .q   (q[RADIX_LOG2:0]),
    .sel (sel)
  );

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (sel)
      ADDM, SUBM:   mag = m_wide;
      ADD2M, SUB2M: mag = m_wide <<< 1;
      ADD3M, SUB3M: mag = m3;
      ADD4M, SUB4M: mag = m_wide <<< 2;
      default:      mag = '0;
    endcase
    neg = (sel == SUBM) || (sel == SUB2M) || (sel == SUB3M) || (sel == SUB4M);
  end

  assign addend  = neg ? -mag : mag;
  assign sum     = acc + addend;
  // ACC and Q form one long shift register; the shifted-out ACC bits land atop Q.
  assign shifted = $signed({sum, q}) >>> RADIX_LOG2;

  always_comb begin
    state_n = state;
    busy    = (state != IDLE);
    done    = (state == DONE);
    case (state)
      IDLE: if (start) state_n = (RADIX_LOG2 == 3) ? PRE : CALC;
      PRE:  state_n = abort ? IDLE : CALC;
      CALC: begin
        if (abort)     state_n = IDLE;
        else if (last) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      m       <= '0;
      m3      <= '0;
      acc     <= '0;
      q       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          m   <= a_ext;
          q   <= {b_wide, 1'b0};
          acc <= '0;
          cnt <= '0;
        end
        PRE: m3 <= m_wide + (m_wide <<< 1);
        CALC: begin
          acc <= shifted[AW+QW-1:QW];
          q   <= shifted[QW-1:0];
          cnt <= cnt + CW'(1);
          // Captured on the last step so Product is already valid while Done is high.
          if (last && !abort) product <= shifted[2*WIDTH:1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: radix-8/8-bit directed vectors and handshake corners,
// plus radix-4/16-bit randomized operands against an arithmetic reference.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st8 = 1'b0, ab8 = 1'b0, sg8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        bz8, dn8;
  logic [15:0] p8;
  logic        st16 = 1'b0, sg16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        bz16, dn16;
  logic [31:0] p16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  booth_mult_seq dut8 (
    .clk(clk), .rst(rst), .start(st8), .abort(ab8), .signed_mode(sg8),
    .a(a8), .b(b8), .busy(bz8), .done(dn8), .product(p8)
  );

  booth_mult_seq #(.WIDTH(16), .RADIX_LOG2(2)) dut16 (
    .clk(clk), .rst(rst), .start(st16), .abort(1'b0), .signed_mode(sg16),
    .a(a16), .b(b16), .busy(bz16), .done(dn16), .product(p16)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Full product of the extended operands, truncated to 2*w bits.
  function automatic logic [31:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input bit sg, input int w);
    longint x, y, mask;
    mask = (64'sd1 << w) - 1;
    x = longint'(av) & mask;
    y = longint'(bv) & mask;
    if (sg && x[w-1]) x = x - (64'sd1 << w);
    if (sg && y[w-1]) y = y - (64'sd1 << w);
    return 32'((x * y) & ((64'sd1 << (2 * w)) - 1));
  endfunction

  // Start one operation, scramble operands after acceptance, wait for Done.
  task automatic do_op(input bit w16, input logic [15:0] av, input logic [15:0] bv,
                       input bit sg, output logic [31:0] p, output int lat);
    p   = '0;
    lat = -1;
    @(negedge clk);
    if (w16) begin a16 = av; b16 = bv; sg16 = sg; st16 = 1'b1; end
    else     begin a8 = av[7:0]; b8 = bv[7:0]; sg8 = sg; st8 = 1'b1; end
    @(posedge clk);
    #1;
    st8 = 1'b0; st16 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sg8 = ~sg8;
    a16 = 16'($urandom); b16 = 16'($urandom); sg16 = ~sg16;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (w16 ? dn16 : dn8) begin
        lat = c;
        p = w16 ? p16 : {16'h0, p8};
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    bit          sg;
    logic [15:0] exp;
  } vec_t;

  initial begin
    vec_t        vt[7];
    logic [31:0] p;
    int          lat;
    logic [15:0] cor[5];

    vt[0] = '{8'h80, 8'h80, 1'b1, 16'd16384};
    vt[1] = '{8'h7F, 8'hFF, 1'b1, 16'hFF81};
    vt[2] = '{8'hFF, 8'hFF, 1'b0, 16'd65025};
    vt[3] = '{8'hFF, 8'hFF, 1'b1, 16'd1};
    vt[4] = '{8'h03, 8'h05, 1'b1, 16'd15};
    vt[5] = '{8'h00, 8'h9C, 1'b1, 16'd0};
    vt[6] = '{8'h80, 8'h7F, 1'b1, 16'hC080};

    #3;
    check("rst_busy", bz8, 0);
    check("rst_done", dn8, 0);
    check("rst_prod", p8, 0);
    check("rst_prod16", p16, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      do_op(1'b0, {8'h0, vt[i].a}, {8'h0, vt[i].b}, vt[i].sg, p, lat);
      check($sformatf("vec%0d_prod", i), p[15:0], vt[i].exp);
      check($sformatf("vec%0d_lat", i), lat, 5);
    end

    // Start held through an operation: one Done, then one IDLE cycle, then the next op.
    @(negedge clk);
    a8 = 8'd7; b8 = 8'd6; sg8 = 1'b1; st8 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("hold_done%0d", c), dn8, (c == 5 || c == 11));
      if (c == 5) begin
        check("hold_p1", p8, 16'd42);
        a8 = 8'hFD; b8 = 8'd9;
      end
      if (c == 6) check("hold_idle", bz8, 0);
      if (c == 7) begin
        check("hold_busy2", bz8, 1);
        st8 = 1'b0;
      end
      if (c == 11) check("hold_p2", p8, 16'hFFE5);
    end

    // Abort in the second CALC cycle.
    @(negedge clk);
    a8 = 8'd50; b8 = 8'd3; sg8 = 1'b0; st8 = 1'b1;
    @(posedge clk);
    #1 st8 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("abort_done%0d", c), dn8, 0);
      if (c == 3) ab8 = 1'b1;
      if (c == 4) begin
        ab8 = 1'b0;
        check("abort_busy", bz8, 0);
      end
    end
    check("abort_prod", p8, 16'hFFE5);
    do_op(1'b0, 16'd50, 16'd3, 1'b0, p, lat);
    check("post_abort", p[15:0], 16'd150);
    check("post_abort_lat", lat, 5);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    a8 = 8'd11; b8 = 8'd13; sg8 = 1'b1; st8 = 1'b1;
    @(posedge clk);
    #1 st8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", bz8, 0);
    check("arst_done", dn8, 0);
    check("arst_prod", p8, 0);
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b0, 16'd3, 16'd5, 1'b1, p, lat);
    check("arst_after", p[15:0], 16'd15);

    // Radix-4, 16-bit: corners then random pairs.
    cor = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};
    for (int s = 0; s < 2; s++)
      foreach (cor[i])
        foreach (cor[j]) begin
          do_op(1'b1, cor[i], cor[j], s[0], p, lat);
          check($sformatf("c16_%0d_%0d_%0d", s, i, j), p, model(cor[i], cor[j], s[0], 16));
          check("c16_lat", lat, 10);
        end
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] av, bv;
      bit          sg;
      av = 16'($urandom);
      bv = 16'($urandom);
      sg = 1'($urandom_range(0, 1));
      do_op(1'b1, av, bv, sg, p, lat);
      check($sformatf("r16_%0d", i), p, model(av, bv, sg, 16));
      check($sformatf("r16_lat_%0d", i), lat, 10);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
